// File: rtl/regfile_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_pkg
// Shared CPU definitions used by the register file / scoreboard and by the
// decoder that drives it.
//   - RF_DATA_W / RF_ADDR_W : default register width and address width.
//   - OP_* opcodes and op_ctrl(): tells decode which register-file strobes an
//     instruction needs, so reservations, moves and writebacks stay coherent.
//   - ZERO_REG_EN : set when the macro REGFILE_ZERO_REG_EN is defined; register
//     0 then becomes a hard-wired zero (writes, moves, reservations ignored).
// -----------------------------------------------------------------------------
package regfile_scoreboard_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    localparam logic [3:0] OP_LW  = 4'd0;
    localparam logic [3:0] OP_SW  = 4'd1;
    localparam logic [3:0] OP_MOV = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;

    // Decode-side strobes for one instruction. Instructions that produce a
    // result later in the pipe reserve their destination; the matching
    // writeback then raises wr_en and clears the reservation.
    typedef struct packed {
        logic mov;      // register-to-register copy at decode
        logic rsv;      // destination pending a later writeback
    } rf_ctrl_t;

    function automatic rf_ctrl_t op_ctrl(input logic [3:0] op);
        rf_ctrl_t c;
        c = '0;
        case (op)
            OP_MOV:  c.mov = 1'b1;
            OP_SW:   c = '0;
            OP_LW, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: c.rsv = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_busy.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_busy
// Per-register busy bits marking pending writebacks.
// Ports:
//   clk, srst-style synchronous active-high rst
//   wr_en/wr_addr   : writeback, clears busy[wr_addr]
//   mov_en/mov_dst  : move, clears busy[mov_dst]
//   rsv_en/rsv_addr : reservation, sets busy[rsv_addr] (wins over clears)
//   busy_next       : busy vector as it will be after this edge (read-through)
//   rsv_err         : registered one-cycle pulse, reservation of a register
//                     that was busy and is not being cleared this cycle
// Strobes arrive already qualified (zero-register filtering is done upstream,
// see REGFILE_ZERO_REG_EN in the package).
// -----------------------------------------------------------------------------
module regfile_scoreboard_busy
    import regfile_scoreboard_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     mov_en,
    input  logic [ADDR_W-1:0]        mov_dst,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(2**ADDR_W)-1:0]   busy_next,
    output logic                     rsv_err
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0] busy_reg;
    logic                rsv_err_reg;
    logic                rsv_cleared;

    // A new reservation dominates a same-cycle clear from writeback or move.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
        assign busy_next[gi] = (rsv_en && (rsv_addr == ADDR_W'(gi))) ||
                               (busy_reg[gi] &&
                                !(wr_en  && (wr_addr == ADDR_W'(gi))) &&
                                !(mov_en && (mov_dst == ADDR_W'(gi))));
    end

    assign rsv_cleared = (wr_en  && (wr_addr == rsv_addr)) ||
                         (mov_en && (mov_dst == rsv_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg    <= '0;
            rsv_err_reg <= 1'b0;
        end else begin
            busy_reg    <= busy_next;
            rsv_err_reg <= rsv_en && busy_reg[rsv_addr] && !rsv_cleared;
        end
    end

    assign rsv_err = rsv_err_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// NUM_REGS x DATA_W register file with busy scoreboard.
// Ports:
//   clk, rst (synchronous, active-high, priority over everything)
//   rd_en, rd_addr_a/b   -> rd_data_a/b, rd_busy_a/b (registered, 1 cycle),
//                           rd_valid (rd_en delayed one cycle)
//   wr_en, wr_addr, wr_data : writeback (clears busy)
//   mov_en, mov_src, mov_dst: copy regs[src] -> regs[dst] (clears busy[dst])
//   rsv_en, rsv_addr        : reserve register (sets busy), rsv_err pulse
// Reads return the post-edge state: same-cycle writes and moves are bypassed,
// a write beats a move to the same destination, and a move always copies the
// pre-edge source value.
// Build option: REGFILE_ZERO_REG_EN makes register 0 a constant zero.
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mov_en,
    input  logic [ADDR_W-1:0] mov_src,
    input  logic [ADDR_W-1:0] mov_dst,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_err
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   regs_mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy_next;
    logic                wr_ok;
    logic                mov_ok;
    logic                rsv_ok;

    logic [ADDR_W-1:0]   rd_addr   [2];
    logic [DATA_W-1:0]   data_next [2];
    logic [DATA_W-1:0]   data_reg  [2];
    logic                busy_reg  [2];
    logic                valid_reg;

    // With a hard-wired zero register every strobe aimed at address 0 is
    // dropped here, so storage, bypass and scoreboard never see it and
    // regs_mem[0] stays at its reset value of 0.
    assign wr_ok  = wr_en  && !(ZERO_REG_EN && (wr_addr  == '0));
    assign mov_ok = mov_en && !(ZERO_REG_EN && (mov_dst  == '0));
    assign rsv_ok = rsv_en && !(ZERO_REG_EN && (rsv_addr == '0));

    regfile_scoreboard_busy #(
        .ADDR_W (ADDR_W)
    ) u_busy (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_ok),
        .wr_addr   (wr_addr),
        .mov_en    (mov_ok),
        .mov_dst   (mov_dst),
        .rsv_en    (rsv_ok),
        .rsv_addr  (rsv_addr),
        .busy_next (busy_next),
        .rsv_err   (rsv_err)
    );

    // Storage. The write is issued after the move so it wins on a shared
    // destination; regs_mem[mov_src] is the pre-edge value by construction.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_mem[i] <= '0;
            end
        end else begin
            if (mov_ok) begin
                regs_mem[mov_dst] <= regs_mem[mov_src];
            end
            if (wr_ok) begin
                regs_mem[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    // Two identical read ports: bypass mux followed by output register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        always_comb begin
            data_next[gi] = regs_mem[rd_addr[gi]];
            if (mov_ok && (mov_dst == rd_addr[gi])) begin
                data_next[gi] = regs_mem[mov_src];
            end
            if (wr_ok && (wr_addr == rd_addr[gi])) begin
                data_next[gi] = wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_reg[gi] <= '0;
                busy_reg[gi] <= 1'b0;
            end else if (rd_en) begin
                data_reg[gi] <= data_next[gi];
                busy_reg[gi] <= busy_next[rd_addr[gi]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= rd_en;
        end
    end

    assign rd_data_a = data_reg[0];
    assign rd_data_b = data_reg[1];
    assign rd_busy_a = busy_reg[0];
    assign rd_busy_b = busy_reg[1];
    assign rd_valid  = valid_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
// Directed scenarios with literal expectations plus a randomized run checked
// against an array-based model of the register file and its busy bits.
// Honours REGFILE_ZERO_REG_EN when the same macro is defined for the bench.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_busy_a, rd_busy_b, rd_valid;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        mov_en;
    logic [4:0]  mov_src, mov_dst;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_err;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    // Reference state: architectural contents and pending-writeback flags.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [31:0] exp_a, exp_b;
    bit          exp_ba, exp_bb, exp_valid, exp_err;

    regfile_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_busy_a (rd_busy_a),
        .rd_busy_b (rd_busy_b),
        .rd_valid  (rd_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mov_en    (mov_en),
        .mov_src   (mov_src),
        .mov_dst   (mov_dst),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_err   (rsv_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply one cycle of stimulus, advance the model, sample 1 time unit
    // after the rising edge. No comparisons here; callers check exp_*.
    task automatic cyc(input bit re, input logic [4:0] ra, input logic [4:0] rb,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit me, input logic [4:0] ms, input logic [4:0] md,
                       input bit se, input logic [4:0] sa);
        logic [31:0] nr [32];
        bit          nb [32];
        bit          we_q, me_q, se_q;
        rst = 1'b0;
        rd_en = re; rd_addr_a = ra; rd_addr_b = rb;
        wr_en = we; wr_addr = wa; wr_data = wd;
        mov_en = me; mov_src = ms; mov_dst = md;
        rsv_en = se; rsv_addr = sa;
        we_q = we && !(ZR && wa == 0);
        me_q = me && !(ZR && md == 0);
        se_q = se && !(ZR && sa == 0);
        nr = m_regs;
        nb = m_busy;
        if (me_q) nr[md] = m_regs[ms];
        if (we_q) nr[wa] = wd;
        if (me_q) nb[md] = 1'b0;
        if (we_q) nb[wa] = 1'b0;
        if (se_q) nb[sa] = 1'b1;
        exp_err = se_q && m_busy[sa] && !(we_q && wa == sa) && !(me_q && md == sa);
        if (re) begin
            exp_a = nr[ra]; exp_b = nr[rb];
            exp_ba = nb[ra]; exp_bb = nb[rb];
        end
        exp_valid = re;
        @(posedge clk);
        #1;
        m_regs = nr;
        m_busy = nb;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [4:0] ra, input logic [4:0] rb);
        cyc(1, ra, rb, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
        cyc(0, 0, 0, 1, wa, wd, 0, 0, 0, 0, 0);
    endtask

    // Reset with every other input active, to exercise reset priority.
    task automatic do_reset();
        rst = 1'b1;
        rd_en = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF;
        mov_en = 1'b1; mov_src = 5'd1; mov_dst = 5'd7;
        rsv_en = 1'b1; rsv_addr = 5'd3;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        exp_a = '0; exp_b = '0; exp_ba = 0; exp_bb = 0; exp_valid = 0; exp_err = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, rd_valid, rsv_err} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got da=%h db=%h ba=%b bb=%b v=%b e=%b required all 0",
                     rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, rd_valid, rsv_err);
        end
        rd(5'd3, 5'd7);
        n_vec++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0 || rd_busy_a !== 1'b0 ||
            rd_busy_b !== 1'b0 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_read_3_7: got da=%h db=%h ba=%b bb=%b v=%b required 0 0 0 0 1",
                     rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, rd_valid);
        end
        $display("test_reset done: %0d vectors so far", n_vec);
    endtask

    task automatic test_write_bypass();
        do_reset();
        cyc(1, 5'd5, 5'd5, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        n_vec++;
        if (rd_data_a !== 32'hDEADBEEF || rd_data_b !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_bypass: got a=%h b=%h required deadbeef", rd_data_a, rd_data_b);
        end
        // rd_en low: outputs hold even while register 5 changes.
        wr(5'd5, 32'h1234_5678);
        n_vec++;
        if (rd_data_a !== 32'hDEADBEEF || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_hold: got a=%h v=%b required deadbeef 0", rd_data_a, rd_valid);
        end
        wr(5'd5, 32'hDEADBEEF);
        idle();
        rd(5'd5, 5'd6);
        n_vec++;
        if (rd_data_a !== 32'hDEADBEEF || rd_data_b !== 32'd0 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL write_reread: got a=%h b=%h v=%b required deadbeef 0 1",
                     rd_data_a, rd_data_b, rd_valid);
        end
        $display("test_write_bypass done: %0d vectors so far", n_vec);
    endtask

    task automatic test_reserve();
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
        n_vec++;
        if (rsv_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rsv_first_err: got %b required 0", rsv_err);
        end
        rd(5'd9, 5'd9);
        n_vec++;
        if (rd_busy_a !== 1'b1 || rd_busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL rsv_busy: got a=%b b=%b required 1 1", rd_busy_a, rd_busy_b);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
        n_vec++;
        if (rsv_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rsv_err_pulse: got %b required 1", rsv_err);
        end
        idle();
        n_vec++;
        if (rsv_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rsv_err_one_cycle: got %b required 0", rsv_err);
        end
        wr(5'd9, 32'h12);
        rd(5'd9, 5'd9);
        n_vec++;
        if (rd_data_a !== 32'h12 || rd_busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rsv_writeback: got d=%h busy=%b required 12 0", rd_data_a, rd_busy_a);
        end
        $display("test_reserve done: %0d vectors so far", n_vec);
    endtask

    task automatic test_move();
        do_reset();
        wr(5'd2, 32'hA);
        wr(5'd4, 32'hB);
        // Move reads pre-edge reg2 while reg2 is overwritten in the same cycle.
        cyc(1, 5'd4, 5'd2, 1, 5'd2, 32'hC, 1, 5'd2, 5'd4, 0, 0);
        n_vec++;
        if (rd_data_a !== 32'hA || rd_data_b !== 32'hC) begin
            n_fail++;
            $display("FAIL move_bypass: got r4=%h r2=%h required a c", rd_data_a, rd_data_b);
        end
        rd(5'd4, 5'd2);
        n_vec++;
        if (rd_data_a !== 32'hA || rd_data_b !== 32'hC) begin
            n_fail++;
            $display("FAIL move_stored: got r4=%h r2=%h required a c", rd_data_a, rd_data_b);
        end
        cyc(1, 5'd4, 5'd4, 1, 5'd4, 32'h55, 1, 5'd2, 5'd4, 0, 0);
        n_vec++;
        if (rd_data_a !== 32'h55 || rd_data_b !== 32'h55) begin
            n_fail++;
            $display("FAIL wr_beats_mov_bypass: got a=%h b=%h required 55", rd_data_a, rd_data_b);
        end
        rd(5'd4, 5'd0);
        n_vec++;
        if (rd_data_a !== 32'h55) begin
            n_fail++;
            $display("FAIL wr_beats_mov_stored: got %h required 55", rd_data_a);
        end
        // A move clears the destination busy bit.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd4);
        cyc(1, 5'd4, 5'd4, 0, 0, 0, 1, 5'd2, 5'd4, 0, 0);
        n_vec++;
        if (rd_busy_a !== 1'b0 || rd_data_a !== 32'hC) begin
            n_fail++;
            $display("FAIL mov_clears_busy: got busy=%b d=%h required 0 c", rd_busy_a, rd_data_a);
        end
        $display("test_move done: %0d vectors so far", n_vec);
    endtask

    task automatic test_wr_rsv_same();
        do_reset();
        wr(5'd2, 32'h99);
        cyc(1, 5'd6, 5'd6, 1, 5'd6, 32'h77, 0, 0, 0, 1, 5'd6);
        n_vec++;
        if (rd_busy_a !== 1'b1 || rd_busy_b !== 1'b1 || rd_data_a !== 32'h77 || rsv_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rsv_same: got busy=%b/%b d=%h err=%b required 1/1 77 0",
                     rd_busy_a, rd_busy_b, rd_data_a, rsv_err);
        end
        // Busy register being cleared this cycle: re-reservation is no error.
        cyc(0, 0, 0, 1, 5'd6, 32'h78, 0, 0, 0, 1, 5'd6);
        n_vec++;
        if (rsv_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rsv_cleared_no_err: got %b required 0", rsv_err);
        end
        do_reset();
        rd(5'd6, 5'd2);
        n_vec++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0 || rd_busy_a !== 1'b0 || rd_busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clears_state: got d=%h/%h busy=%b/%b required 0",
                     rd_data_a, rd_data_b, rd_busy_a, rd_busy_b);
        end
        $display("test_wr_rsv_same done: %0d vectors so far", n_vec);
    endtask

    task automatic test_zero_reg();
        do_reset();
        cyc(1, 5'd0, 5'd0, 1, 5'd0, 32'hFF, 0, 0, 0, 1, 5'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0);
        n_vec++;
`ifdef REGFILE_ZERO_REG_EN
        if (rsv_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_rsv_err: got %b required 0", rsv_err);
        end
        rd(5'd0, 5'd0);
        n_vec++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0 || rd_busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_read: got d=%h/%h busy=%b required 0 0 0",
                     rd_data_a, rd_data_b, rd_busy_a);
        end
`else
        if (rsv_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reg0_rsv_err: got %b required 1", rsv_err);
        end
        rd(5'd0, 5'd0);
        n_vec++;
        if (rd_data_a !== 32'hFF || rd_data_b !== 32'hFF || rd_busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL reg0_ordinary: got d=%h/%h busy=%b required ff ff 1",
                     rd_data_a, rd_data_b, rd_busy_a);
        end
`endif
        $display("test_zero_reg done: %0d vectors so far", n_vec);
    endtask

    // Random traffic on a small address window so collisions are frequent.
    task automatic test_random();
        do_reset();
        for (int t = 0; t < 600; t++) begin
            cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
            n_vec++;
            if (rd_data_a !== exp_a || rd_data_b !== exp_b) begin
                n_fail++;
                $display("FAIL rand_data cycle %0d: got %h/%h required %h/%h",
                         t, rd_data_a, rd_data_b, exp_a, exp_b);
            end
            n_vec++;
            if (rd_busy_a !== exp_ba || rd_busy_b !== exp_bb) begin
                n_fail++;
                $display("FAIL rand_busy cycle %0d: got %b/%b required %b/%b",
                         t, rd_busy_a, rd_busy_b, exp_ba, exp_bb);
            end
            n_vec++;
            if (rd_valid !== exp_valid || rsv_err !== exp_err) begin
                n_fail++;
                $display("FAIL rand_valid_err cycle %0d: got v=%b e=%b required v=%b e=%b",
                         t, rd_valid, rsv_err, exp_valid, exp_err);
            end
        end
        $display("test_random done: %0d vectors so far", n_vec);
    endtask

    initial begin
        rst = 1'b1;
        rd_en = 0; rd_addr_a = 0; rd_addr_b = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        mov_en = 0; mov_src = 0; mov_dst = 0;
        rsv_en = 0; rsv_addr = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_bypass();
        test_reserve();
        test_move();
        test_wr_rsv_same();
        test_zero_reg();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
